// File: rtl/parallel_uart_tx_if.sv
// Store-bus bundle between the processor's write datapath and the UART
// transmitter: the write strobe, the ALU-computed address and the rd2 byte.
interface parallel_uart_tx_if;
    logic       we;
    logic [7:0] address;
    logic [7:0] wdata;

    // The CPU store path drives the bundle
    modport master (output we, address, wdata);

    // The UART transmitter only observes it
    modport slave (input we, address, wdata);
endinterface

// File: rtl/parallel_uart_tx.sv
// Buffered 8N1 UART transmitter for CPU store output. Bytes stored to
// PORT_ADDR are queued in a small circular FIFO and shifted out LSB first on
// txd. Back-to-back bytes are sent with no idle gap between frames.
module parallel_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  PORT_ADDR    = 8'hFE
) (
    input  logic                          clk,
    input  logic                          rst,
    parallel_uart_tx_if.slave             bus,
    input  logic                          clr_ovf,
    output logic                          txd,
    output logic                          busy,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = PW + 1;
    localparam logic [15:0]     BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]   LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    tx_state_t      state;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    logic           push_req;
    logic           push;
    logic           pop;
    logic           bit_done;

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_FULL);
    assign busy     = (state != IDLE);
    assign bit_done = (baud_cnt == BAUD_LAST);

    // The FSM takes the head byte when idle, or at the very last stop-bit
    // cycle so the next start bit follows without a gap
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_done));

    // A full FIFO still accepts a byte when a slot frees up on the same edge
    assign push_req = bus.we && (bus.address == PORT_ADDR);
    assign push     = push_req && (!full || pop);

    // FIFO storage is deliberately left out of reset; only pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.wdata;
        end
    end

    // Pointer and occupancy bookkeeping, with pointers wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && !push) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Serializer FSM; txd is registered so no input reaches the line directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            txd       <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        txd       <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        txd      <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            bit_idx   <= '0;
                            txd       <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_uart_tx.sv
// Directed bench for parallel_uart_tx with 4 clocks per bit and a 4-deep FIFO.
// txd/busy/level are logged once per cycle and decoded against byte lists.
module tb_parallel_uart_tx;

    localparam int         CPB  = 4;
    localparam int         DEPTH = 4;
    localparam logic [7:0] ADDR = 8'hFE;

    logic       clk;
    logic       rst;
    logic       clr_ovf;
    logic       txd;
    logic       busy;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    parallel_uart_tx_if bus_if ();

    parallel_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .PORT_ADDR    (ADDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if.slave),
        .clr_ovf  (clr_ovf),
        .txd      (txd),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    int total_checks = 0;
    int bad_checks   = 0;

    logic       logging = 1'b0;
    logic       txd_q   [$];
    logic       busy_q  [$];
    logic [2:0] level_q [$];
    logic [7:0] exp_bytes [$];

    // Free-running 100 MHz style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle log of the line, taken on the falling edge
    always @(negedge clk) begin
        if (logging) begin
            txd_q.push_back(txd);
            busy_q.push_back(busy);
            level_q.push_back(level);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data, input logic clr);
        bus_if.we      = 1'b1;
        bus_if.address = addr;
        bus_if.wdata   = data;
        clr_ovf        = clr;
        waitCycles(1);
        bus_if.we      = 1'b0;
        clr_ovf        = 1'b0;
    endtask

    task automatic startLog();
        txd_q.delete();
        busy_q.delete();
        level_q.delete();
        exp_bytes.delete();
        logging = 1'b1;
    endtask

    // Finds the first start bit, then compares each 40-cycle frame to the
    // expected 8N1 pattern and confirms the line is idle right after
    task automatic checkStream(input string tag);
        int         start;
        int         n;
        int         busy_cnt;
        logic [9:0] fb;
        logic [39:0] obs;
        logic [39:0] expv;
        n     = exp_bytes.size();
        start = -1;
        foreach (txd_q[i]) begin
            if (start < 0 && txd_q[i] == 1'b0) start = i;
        end
        checkOutput({tag, "_latency"}, 64'(start), 64'd2);
        if (start < 0) return;
        if (start + 40 * n >= txd_q.size()) begin
            checkOutput({tag, "_loglen"}, 64'(txd_q.size()), 64'(start + 40 * n + 1));
            return;
        end
        for (int i = 0; i < n; i++) begin
            fb = {1'b1, exp_bytes[i], 1'b0};
            for (int k = 0; k < 40; k++) begin
                obs[k]  = txd_q[start + 40 * i + k];
                expv[k] = fb[k / CPB];
            end
            checkOutput($sformatf("%s_frame%0d", tag, i), 64'(obs), 64'(expv));
        end
        busy_cnt = 0;
        for (int k = start; k < start + 40 * n; k++) begin
            if (busy_q[k] == 1'b1) busy_cnt++;
        end
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(40 * n));
        checkOutput({tag, "_idle_txd"}, 64'(txd_q[start + 40 * n]), 64'd1);
        checkOutput({tag, "_idle_busy"}, 64'(busy_q[start + 40 * n]), 64'd0);
    endtask

    initial begin
        int zeros;
        int peak;

        // Reset held with random bus activity
        rst            = 1'b1;
        clr_ovf        = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.address = 8'h00;
        bus_if.wdata   = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus_if.we      = 1'($urandom_range(0, 1));
            bus_if.address = 8'($urandom_range(0, 255));
            bus_if.wdata   = 8'($urandom_range(0, 255));
            clr_ovf        = 1'($urandom_range(0, 1));
        end
        waitCycles(1);
        checkOutput("rst_txd",      64'(txd),      64'd1);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        checkOutput("rst_empty",    64'(empty),    64'd1);
        checkOutput("rst_full",     64'(full),     64'd0);
        checkOutput("rst_level",    64'(level),    64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        bus_if.we = 1'b0;
        clr_ovf   = 1'b0;
        rst       = 1'b0;
        waitCycles(3);
        $display("[TB] reset released");

        // Single byte 0xA5
        startLog();
        exp_bytes.push_back(8'hA5);
        applyStimulus(ADDR, 8'hA5, 1'b0);
        checkOutput("single_level", 64'(level), 64'd1);
        checkOutput("single_empty", 64'(empty), 64'd0);
        waitCycles(50);
        logging = 1'b0;
        checkStream("single");
        checkOutput("single_end_empty", 64'(empty), 64'd1);

        // Write to a neighbouring address is ignored
        startLog();
        applyStimulus(ADDR - 8'd1, 8'h3C, 1'b0);
        checkOutput("filter_level", 64'(level), 64'd0);
        waitCycles(12);
        logging = 1'b0;
        zeros = 0;
        foreach (txd_q[i]) if (txd_q[i] == 1'b0 || busy_q[i] == 1'b1) zeros++;
        checkOutput("filter_no_frame", 64'(zeros), 64'd0);

        // Four consecutive writes become four gapless frames
        startLog();
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(ADDR, 8'h01, 1'b0);
        applyStimulus(ADDR, 8'h02, 1'b0);
        applyStimulus(ADDR, 8'h03, 1'b0);
        applyStimulus(ADDR, 8'h04, 1'b0);
        waitCycles(170);
        logging = 1'b0;
        checkStream("burst");
        peak = 0;
        foreach (level_q[i]) if (int'(level_q[i]) > peak) peak = int'(level_q[i]);
        checkOutput("burst_peak_level", 64'(peak), 64'd3);
        checkOutput("burst_overflow",   64'(overflow), 64'd0);

        // Six writes during a frame: last two dropped, clear collides with a drop
        startLog();
        exp_bytes = '{8'hA0, 8'h10, 8'h11, 8'h12, 8'h13};
        applyStimulus(ADDR, 8'hA0, 1'b0);
        waitCycles(3);
        applyStimulus(ADDR, 8'h10, 1'b0);
        applyStimulus(ADDR, 8'h11, 1'b0);
        applyStimulus(ADDR, 8'h12, 1'b0);
        applyStimulus(ADDR, 8'h13, 1'b0);
        checkOutput("ovf_full_before_drop", 64'(full),     64'd1);
        checkOutput("ovf_flag_before_drop", 64'(overflow), 64'd0);
        applyStimulus(ADDR, 8'h14, 1'b0);
        checkOutput("ovf_flag_set",   64'(overflow), 64'd1);
        checkOutput("ovf_level_held", 64'(level),    64'd4);
        applyStimulus(ADDR, 8'h15, 1'b1);
        checkOutput("ovf_set_wins",   64'(overflow), 64'd1);
        checkOutput("ovf_full",       64'(full),     64'd1);
        waitCycles(200);
        logging = 1'b0;
        checkStream("ovf");
        clr_ovf = 1'b1;
        waitCycles(1);
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", 64'(overflow), 64'd0);

        // Write to a full FIFO on the same edge as the stop-to-start pop
        startLog();
        exp_bytes = '{8'hB0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        applyStimulus(ADDR, 8'hB0, 1'b0);
        applyStimulus(ADDR, 8'hC0, 1'b0);
        applyStimulus(ADDR, 8'hC1, 1'b0);
        applyStimulus(ADDR, 8'hC2, 1'b0);
        applyStimulus(ADDR, 8'hC3, 1'b0);
        waitCycles(36);
        checkOutput("popfull_full_before", 64'(full), 64'd1);
        applyStimulus(ADDR, 8'hC4, 1'b0);
        checkOutput("popfull_level",    64'(level),    64'd4);
        checkOutput("popfull_overflow", 64'(overflow), 64'd0);
        waitCycles(250);
        logging = 1'b0;
        checkStream("popfull");

        // Reset asserted in the middle of a frame of zero bits
        applyStimulus(ADDR, 8'h00, 1'b0);
        applyStimulus(ADDR, 8'h55, 1'b0);
        applyStimulus(ADDR, 8'h66, 1'b0);
        waitCycles(8);
        checkOutput("midrst_txd_low",  64'(txd),   64'd0);
        checkOutput("midrst_level",    64'(level), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_txd_high", 64'(txd),   64'd1);
        checkOutput("midrst_busy",     64'(busy),  64'd0);
        checkOutput("midrst_empty",    64'(empty), 64'd1);
        checkOutput("midrst_level0",   64'(level), 64'd0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(6);
        checkOutput("postrst_txd",  64'(txd),  64'd1);
        checkOutput("postrst_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/parallel_uart_tx.md
# parallel_uart_tx

Buffered UART transmitter hung off the processor's parallel output path. It captures bytes written by store instructions to a dedicated output address into a small FIFO, then serializes them 8N1, LSB first, on `UART_TXD`. It is the downstream consumer of the store datapath (`MemWrite`, ALU address, `rd2` data), so CPU output can leave the board without stalling the core.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, 2..16.
- `PORT_ADDR`, 8'hFE, store address that targets this block.
- `clk`  in  1  single clock for all logic (CLOCK_50 domain).
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  store strobe, one-cycle pulse synchronous to `clk`.
- `address`  in  8  store address.
- `wdata`  in  8  store data byte.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a write was dropped because FIFO was full.

## Operation
- Push: `we && address == PORT_ADDR` is a write request. Accepted when `!full`, or when `full` and a pop occurs in the same cycle. Otherwise byte is dropped, FIFO unchanged, `overflow` set.
- `clr_ovf` clears `overflow`; if a drop and `clr_ovf` coincide, `overflow` stays 1 (set wins).
- Writes to any other address are ignored.
- FIFO: circular buffer, read/write pointers wrap modulo `FIFO_DEPTH`; `level` = pushes minus pops; `full` = (`level` == `FIFO_DEPTH`), `empty` = (`level` == 0). Simultaneous push and pop leaves `level` unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If `!empty`: pop head into shift register, clear bit counter and baud counter, go START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `txd` = shift[0]; after `CLKS_PER_BIT` cycles shift right, increment bit index; after bit 7 go STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. At the last cycle: if `!empty`, pop and go directly to START (no idle gap); else go IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and resets at each bit boundary; 16-bit wide.
- `busy` = (state != IDLE).
- `txd` is driven from a register. No combinational path exists from any input to `txd`.

## Timing
- Reset values (asserted asynchronously): `txd`=1, `busy`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0, state IDLE, pointers 0. FIFO contents are not reset.
- Reset mid-frame: `txd` returns high immediately, the frame is aborted, and the FIFO is emptied. After release, the block is in IDLE.
- Write accepted at edge N: `level`/`empty` update after edge N. FSM pops at edge N+1. `txd` falls and `busy` rises after edge N+1.
- Frame length: exactly 10 × `CLKS_PER_BIT` cycles from `txd` falling to the end of the stop bit.
- Back-to-back bytes: the next start bit begins on the cycle after the previous stop bit's last cycle.
- `overflow` rises after the edge at which the dropped write is sampled.
- A pop caused by the FSM decrements `level` on that same edge.

## Test plan
- Reset: hold `rst`=1 with random inputs. Required: `txd`=1, `busy`=0, `empty`=1, `level`=0, `overflow`=0. Asserting `rst` mid-frame forces `txd`=1 within the same cycle.
- Single byte, `CLKS_PER_BIT`=4: write 8'hA5 to `PORT_ADDR`. Required: `txd` falls 2 edges after the write. Then, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. `busy` drops after 40 cycles and `empty`=1.
- Address filter: write 8'h3C to `PORT_ADDR`-1. Required: `level` stays 0, `txd` stays 1, no frame.
- Burst: write 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles. Required: `level` peaks at 3 (the first byte is popped), four contiguous frames with no idle gap, 160 cycles total, `overflow`=0.
- Overflow: while the first frame transmits, write six bytes 8'h10..8'h15 with FIFO_DEPTH=4. Required: the last two bytes are dropped, `full`=1, `overflow`=1. Transmitted bytes are the first, then 8'h10..8'h13. `clr_ovf` then clears `overflow`.
- Push on full with pop: fill the FIFO, then issue a write in the same cycle the STOP→START pop occurs. Required: the write is accepted, `level` stays `FIFO_DEPTH`, and `overflow`=0.
